diag_flash_sched: RTL and testbench

- Round-robin scheduler that shares one diagnostic LED output among NREQ status requesters.
- Each granted requester gets a blink code: N flashes, then an inter-code gap. The next pending requester is then served.
- Sits between subsystem status flags (PLL lock, FIFO errors, codec faults) and the board LED pin. Replaces per-clock free-running flashers where pins are scarce.

---
 rtl/diag_pkg.sv | 20 ++
 rtl/diag_tick.sv | 29 ++
 rtl/diag_flash_sched.sv | 162 ++++++++++++++++
 tb/tb_diag_flash_sched.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/diag_pkg.sv
// Shared definitions for the diagnostic LED flashers: phase encoding and a
// width helper for parameter-derived counters.
package diag_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ON   = 2'd1,
        S_OFF  = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    // Bits needed to index v distinct values; never returns less than 1.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) r++;
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/diag_tick.sv
// Loadable down-counting prescaler: tick_c is high for the one cycle the
// count sits at zero; restart re-arms a full period.
module diag_tick #(
    parameter int unsigned W   = 24,
    parameter int unsigned DIV = 3072000
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic tick_c
);

    localparam logic [W-1:0] RELOAD = W'(DIV - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= RELOAD;
        end else if (restart || (cnt == '0)) begin
            cnt <= RELOAD;
        end else begin
            cnt <= cnt - W'(1);
        end
    end

    assign tick_c = (cnt == '0);

endmodule

// File: rtl/diag_flash_sched.sv
// Round-robin sharing of one diagnostic LED: each granted requester blinks
// its latched flash count, followed by a dark gap, before the next is served.
module diag_flash_sched
    import diag_pkg::*;
#(
    parameter int unsigned NREQ      = 4,
    parameter int unsigned CW        = 3,
    parameter int unsigned TBITS     = 24,
    parameter int unsigned TICK_DIV  = 3072000,
    parameter int unsigned ON_TICKS  = 2,
    parameter int unsigned OFF_TICKS = 2,
    parameter int unsigned GAP_TICKS = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*CW-1:0]   code,
    output logic                 out,
    output logic                 busy,
    output logic [NREQ-1:0]      grant,
    output logic                 done
);

    localparam int unsigned MAX_OO = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
    localparam int unsigned MAXT   = (MAX_OO > GAP_TICKS) ? MAX_OO : GAP_TICKS;
    localparam int unsigned PHW    = clog2(MAXT + 1);
    localparam int unsigned PW     = clog2(NREQ);

    localparam logic [PHW-1:0] ON_LAST  = PHW'(ON_TICKS - 1);
    localparam logic [PHW-1:0] OFF_LAST = PHW'(OFF_TICKS - 1);
    localparam logic [PHW-1:0] GAP_LAST = PHW'(GAP_TICKS - 1);

    state_t          state_q, state_n;
    logic [PW-1:0]   ptr_q, ptr_n;
    logic [CW-1:0]   rem_q, rem_n;
    logic [PHW-1:0]  ph_q, ph_n;
    logic            out_n, busy_n, done_n;
    logic [NREQ-1:0] grant_n;
    logic            restart_c, tick_c;
    logic            found_c;
    logic [PW-1:0]   pick_c, idx_c;
    logic [CW-1:0]   pcode_c;

    diag_tick #(
        .W   (TBITS),
        .DIV (TICK_DIV)
    ) u_tick (
        .clk     (clk),
        .reset   (reset),
        .restart (restart_c),
        .tick_c  (tick_c)
    );

    // First pending requester at or after the pointer; scanning downwards
    // lets the nearest one overwrite farther candidates.
    always_comb begin
        found_c = 1'b0;
        pick_c  = '0;
        idx_c   = '0;
        pcode_c = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx_c = PW'((32'(ptr_q) + 32'(k)) % NREQ);
            if (req[idx_c]) begin
                found_c = 1'b1;
                pick_c  = idx_c;
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (pick_c == PW'(i)) pcode_c = code[i*CW +: CW];
        end
    end

    always_comb begin
        state_n   = state_q;
        ptr_n     = ptr_q;
        rem_n     = rem_q;
        ph_n      = ph_q;
        out_n     = out;
        busy_n    = busy;
        grant_n   = grant;
        done_n    = 1'b0;
        restart_c = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (found_c) begin
                    grant_n   = {{(NREQ-1){1'b0}}, 1'b1} << pick_c;
                    busy_n    = 1'b1;
                    ptr_n     = (pick_c == PW'(NREQ - 1)) ? '0 : pick_c + PW'(1);
                    rem_n     = pcode_c;
                    ph_n      = '0;
                    restart_c = 1'b1;
                    if (pcode_c != '0) begin
                        out_n   = 1'b1;
                        state_n = S_ON;
                    end else begin
                        state_n = S_GAP;
                    end
                end
            end
            S_ON: begin
                if (tick_c) begin
                    if (ph_q == ON_LAST) begin
                        ph_n    = '0;
                        rem_n   = rem_q - CW'(1);
                        out_n   = 1'b0;
                        state_n = (rem_q == CW'(1)) ? S_GAP : S_OFF;
                    end else begin
                        ph_n = ph_q + PHW'(1);
                    end
                end
            end
            S_OFF: begin
                if (tick_c) begin
                    if (ph_q == OFF_LAST) begin
                        ph_n    = '0;
                        out_n   = 1'b1;
                        state_n = S_ON;
                    end else begin
                        ph_n = ph_q + PHW'(1);
                    end
                end
            end
            S_GAP: begin
                if (tick_c) begin
                    if (ph_q == GAP_LAST) begin
                        ph_n    = '0;
                        done_n  = 1'b1;
                        grant_n = '0;
                        busy_n  = 1'b0;
                        state_n = S_IDLE;
                    end else begin
                        ph_n = ph_q + PHW'(1);
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            rem_q   <= '0;
            ph_q    <= '0;
            out     <= 1'b0;
            busy    <= 1'b0;
            grant   <= '0;
            done    <= 1'b0;
        end else begin
            state_q <= state_n;
            ptr_q   <= ptr_n;
            rem_q   <= rem_n;
            ph_q    <= ph_n;
            out     <= out_n;
            busy    <= busy_n;
            grant   <= grant_n;
            done    <= done_n;
        end
    end

endmodule

// File: tb/tb_diag_flash_sched.sv
// Scoreboard bench for diag_flash_sched: stimulus pushes the expected blink
// code per grant, a monitor measures the LED waveform and checks each at done.
module tb_diag_flash_sched;

    localparam int unsigned NREQ = 4;
    localparam int unsigned CW   = 3;
    localparam int unsigned TD   = 4;
    localparam int unsigned ONT  = 2;
    localparam int unsigned OFFT = 1;
    localparam int unsigned GAPT = 3;

    typedef struct {
        int idx;
        int n;
        int dur;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 reset = 1'b0;
    logic [NREQ-1:0]      req = '0;
    logic [NREQ*CW-1:0]   code = '0;
    logic                 out, busy, done;
    logic [NREQ-1:0]      grant;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   ptr_m = 0;

    diag_flash_sched #(
        .NREQ      (NREQ),
        .CW        (CW),
        .TBITS     (8),
        .TICK_DIV  (TD),
        .ON_TICKS  (ONT),
        .OFF_TICKS (OFFT),
        .GAP_TICKS (GAPT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .code  (code),
        .out   (out),
        .busy  (busy),
        .grant (grant),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int want);
        tests++;
        if (act != want) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, want, $time);
        end
    endtask

    // Reference arbitration: first set request at or after the pointer.
    function automatic int rr_pick(input logic [NREQ-1:0] r, input int p);
        for (int k = 0; k < NREQ; k++) begin
            if (r[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return 0;
    endfunction

    // Clocks from grant to done for a code of n flashes.
    function automatic int code_clocks(input int n);
        if (n == 0) return GAPT * TD;
        return (n * (ONT + OFFT) - OFFT + GAPT) * TD;
    endfunction

    // Called at a falling edge with the DUT idle or on its done cycle.
    task automatic issue(input logic [NREQ-1:0] r, input logic [NREQ*CW-1:0] c);
        exp_t e;
        e.idx = rr_pick(r, ptr_m);
        e.n   = int'(c[e.idx*CW +: CW]);
        e.dur = code_clocks(e.n);
        exp_q.push_back(e);
        ptr_m = (e.idx + 1) % NREQ;
        req   = r;
        code  = c;
        @(negedge clk);
        check("grant_latency", int'(grant), 1 << e.idx);
        check("out_latency", int'(out), (e.n != 0) ? 1 : 0);
    endtask

    task automatic wait_done();
        for (int t = 0; t < 400; t++) begin
            if (done) return;
            @(negedge clk);
        end
        check("done_timeout", 0, 1);
    endtask

    task automatic do_reset();
        req = '0;
        @(negedge clk);
        reset = 1'b0;
        ptr_m = 0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    // Monitor: measures each served code and checks it against the queue.
    initial begin : monitor
        logic            prev_out;
        int              run, flashes, bcyc;
        logic [NREQ-1:0] cap;
        exp_t            e;
        prev_out = 1'b0; run = 0; flashes = 0; bcyc = 0; cap = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                prev_out = 1'b0; run = 0; flashes = 0; bcyc = 0; cap = '0;
            end else begin
                if (busy) begin
                    if (bcyc == 0) cap = grant;
                    bcyc++;
                    check("grant_onehot", int'($onehot(grant)), 1);
                    if (out != prev_out) begin
                        if (out) begin
                            if (flashes > 0) check("dark_len", run, OFFT * TD);
                            flashes++;
                        end else begin
                            check("lit_len", run, ONT * TD);
                        end
                        run = 0;
                    end
                    run++;
                end else if (out) begin
                    check("out_while_idle", 1, 0);
                end
                if (done) begin
                    check("done_cycle_idle", int'({busy, |grant}), 0);
                    if (exp_q.size() == 0) begin
                        check("unexpected_done", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("served_req", int'(cap), 1 << e.idx);
                        check("flash_count", flashes, e.n);
                        check("code_clocks", bcyc, e.dur);
                        if (e.n > 0) check("gap_len", run, GAPT * TD);
                    end
                    flashes = 0; bcyc = 0; run = 0;
                end
                prev_out = out;
            end
        end
    end

    initial begin : stimulus
        logic [NREQ-1:0]    r;
        logic [NREQ*CW-1:0] c;
        repeat (3) @(negedge clk);
        check("reset_outputs", int'({out, busy, grant, done}), 0);
        reset = 1'b1;
        @(negedge clk);

        // Single code of three flashes from requester 0.
        issue(4'b0001, 12'd3);
        wait_done();
        req = '0;

        // Round robin with 0, 1 and 3 pending and held.
        do_reset();
        repeat (6) begin
            issue(4'b1011, {3'd1, 3'd0, 3'd2, 3'd1});
            wait_done();
        end

        // Silent slot.
        issue(4'b0100, 12'd0);
        wait_done();

        // Code and request changed after grant are ignored.
        issue(4'b0001, 12'd2);
        code = 12'd7;
        req  = '0;
        wait_done();
        repeat (20) @(negedge clk);
        check("no_regrant", int'(grant), 0);

        // Maximum flash count.
        issue(4'b0010, 12'(7 << 3));
        wait_done();

        // Reset asserted mid-flash.
        issue(4'b0100, 12'(5 << 6));
        repeat (2) @(negedge clk);
        #1 reset = 1'b0;
        #1;
        check("rst_async_out", int'(out), 0);
        check("rst_async_busy", int'(busy), 0);
        check("rst_async_grant", int'(grant), 0);
        exp_q.delete();
        ptr_m = 0;
        req   = 4'b1001;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        issue(4'b1001, {3'd1, 3'd0, 3'd0, 3'd2});
        wait_done();

        // Randomized traffic with occasional post-grant disturbance.
        repeat (20) begin
            r = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            c = (NREQ*CW)'($urandom);
            issue(r, c);
            if ($urandom_range(0, 1) == 1) begin
                req  = NREQ'($urandom);
                code = (NREQ*CW)'($urandom);
            end
            wait_done();
        end
        req = '0;
        repeat (5) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
